sh7604_ibus_master: RTL and testbench
=====================================

SH7604_IBUS_MASTER -- requirements
Module: sh7604_ibus_master

Interface
REQ-001 The block SHALL have parameter TO_MAX, default 8'd255, meaning the CE_R count of IBUS_BUSY tolerated before a bus timeout.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock.
REQ-003 The block SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports CE_R / CE_F, input, 1 each, rising and falling clock enables.
REQ-005 The block SHALL have port EN, input, 1; while low, state, counters and outputs are frozen.
REQ-006 The block SHALL have CPU-side ports:
- CPU_A: input, 32, access address.
- CPU_DI: input, 32, write data, right-justified.
- CPU_SZ: input, 2, access size (0 byte, 1 word, 2 long).
- CPU_WE: input, 1, write strobe.
- CPU_REQ: input, 1, access request.
REQ-007 The block SHALL have CPU-side results CPU_DO (output, 32, read data, right-justified, zero-extended) and CPU_ACK (output, 1, one-CE_R completion pulse).
REQ-008 The block SHALL have CPU-side flags CPU_AERR (output, 1, misalignment) and CPU_BERR (output, 1, unmapped or timeout), both valid with CPU_ACK.
REQ-009 The block SHALL have bus-side ports IBUS_A (output, 32), IBUS_DO (output, 32, write data), IBUS_BA (output, 4, byte enables), IBUS_WE (output, 1) and IBUS_REQ (output, 1).
REQ-010 The block SHALL have bus-side ports IBUS_DI (input, 32, OR-combined peripheral read data), IBUS_BUSY (input, 1) and IBUS_ACT (input, 1, some peripheral decodes IBUS_A).

Function
REQ-011 State machine states SHALL be IDLE, REQ, WAIT and DONE, advancing only on CE_R with EN high.
REQ-012 IDLE SHALL behave as follows when CPU_REQ is high:
- Misaligned access (word with A[0]=1, long with A[1:0]!=0): go to DONE with AERR=1, no bus cycle.
- Otherwise: latch A/DI/SZ/WE and go to REQ.
REQ-013 In REQ and WAIT the block SHALL hold IBUS_REQ=1, and IBUS_A/IBUS_WE/IBUS_BA/IBUS_DO SHALL be stable.
REQ-014 IBUS_BA SHALL be big-endian:
- byte: 4'b1000>>A[1:0].
- word: A[1]=0 gives 1100, A[1]=1 gives 0011.
- long: 1111.
REQ-015 IBUS_DO SHALL replicate write data: byte as {4{DI[7:0]}}, word as {2{DI[15:0]}}, long unchanged.
REQ-016 At the first CE_R in REQ and each CE_R in WAIT:
- IBUS_BUSY=1: go to or stay in WAIT and increment the timeout counter.
- Otherwise: go to DONE.
REQ-017 On leaving REQ/WAIT for DONE the block SHALL capture IBUS_DI (lane at A[1:0]: 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0]; word lane per A[1]; long full), zero-extended into CPU_DO.
REQ-018 If IBUS_ACT is low at that capture, the block SHALL set CPU_DO=0 and BERR=1.
REQ-019 On a write, CPU_DO SHALL be left unchanged.
REQ-020 When the timeout counter reaches TO_MAX while BUSY remains high, the block SHALL go to DONE with BERR=1 and CPU_DO=0.
REQ-021 DONE SHALL last one CE_R period, with IBUS_REQ=0, CPU_ACK=1 and AERR/BERR valid, then return to IDLE.
REQ-022 CPU_ACK, AERR and BERR SHALL be low outside DONE.
REQ-023 A CPU_REQ still high in DONE SHALL NOT start a new access until IDLE, giving a minimum 3 CE_R periods per access.
REQ-024 Changes to CPU inputs during REQ/WAIT SHALL be ignored.
REQ-025 CE_F SHALL NOT alter state; it is provided for timing alignment only.

Reset
REQ-026 While RST_N is low the block SHALL hold: state IDLE, timeout counter 0, IBUS_REQ=0, IBUS_WE=0, IBUS_BA=0, IBUS_A=0, IBUS_DO=0, CPU_DO=0, CPU_ACK=0, AERR=0, BERR=0.
REQ-027 Reset asserted mid-access SHALL abort the access immediately with no ACK, and the first CE_R after release SHALL sample CPU_REQ in IDLE.

Structure
REQ-028 The size encoding enum (IBUS_SZ_t) and the state enum (IBUS_ST_t) SHALL reside in SH7604_PKG.
REQ-029 Lane select and lane extract SHALL be package functions; no sub-module is required.

Verification
REQ-030 Scenario byte write: write byte 0x5A at 0xFFFFFE91 with a peripheral ACT=1, BUSY=0 -> IBUS_BA=0100, IBUS_DO=0x5A5A5A5A, IBUS_REQ high one CE_R period, ACK 2 CE_R periods after request, BERR=0.
REQ-031 Scenario byte read: peripheral returns 0x00070000 at A=...91 -> CPU_DO=0x00000007, ACK pulse, BERR=0.
REQ-032 Scenario wait states: BUSY held 3 CE_R periods -> IBUS_REQ high 4 CE_R periods, fields stable, ACK after BUSY falls.
REQ-033 Scenario errors:
- Long access at 0x...02 -> AERR=1 with ACK, IBUS_REQ never asserted.
- Read with ACT=0 -> CPU_DO=0, BERR=1.
- BUSY stuck high -> BERR=1 after TO_MAX CE_R.
REQ-034 Scenario reset/EN: RST_N low during WAIT -> all outputs per REQ-026 immediately; EN low for 5 cycles mid-access -> no state change, access completes normally after EN returns.

Source files
------------

// File: rtl/SH7604_PKG.sv
// SH7604 internal-bus shared types and lane helpers.
// Size/state enums plus byte-lane select, write replicate and read extract.
package SH7604_PKG;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2
    } IBUS_SZ_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } IBUS_ST_t;

    // Encoding 3 is undefined on the CPU side; treat it as a long access.
    function automatic IBUS_SZ_t sz_decode(
        input logic [1:0] sz
    );
        case (sz)
            2'd0:    sz_decode = SZ_BYTE;
            2'd1:    sz_decode = SZ_WORD;
            default: sz_decode = SZ_LONG;
        endcase
    endfunction

    function automatic logic misaligned(
        input IBUS_SZ_t   sz,
        input logic [1:0] a
    );
        case (sz)
            SZ_BYTE: misaligned = 1'b0;
            SZ_WORD: misaligned = a[0];
            default: misaligned = (a != 2'd0);
        endcase
    endfunction

    // Big-endian byte enables: bit 3 is the lane at address offset 0.
    function automatic logic [3:0] lane_sel(
        input IBUS_SZ_t   sz,
        input logic [1:0] a
    );
        case (sz)
            SZ_BYTE: lane_sel = 4'b1000 >> a;
            SZ_WORD: lane_sel = a[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Replicating write data means the peripheral may pick any lane.
    function automatic logic [31:0] lane_wdata(
        input IBUS_SZ_t    sz,
        input logic [31:0] di
    );
        case (sz)
            SZ_BYTE: lane_wdata = {4{di[7:0]}};
            SZ_WORD: lane_wdata = {2{di[15:0]}};
            default: lane_wdata = di;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(
        input IBUS_SZ_t    sz,
        input logic [1:0]  a,
        input logic [31:0] di
    );
        logic [31:0] r;
        r = 32'h0;
        case (sz)
            SZ_BYTE: begin
                case (a)
                    2'd0:    r = {24'h0, di[31:24]};
                    2'd1:    r = {24'h0, di[23:16]};
                    2'd2:    r = {24'h0, di[15:8]};
                    default: r = {24'h0, di[7:0]};
                endcase
            end
            SZ_WORD: begin
                r = a[1] ? {16'h0, di[15:0]}
                         : {16'h0, di[31:16]};
            end
            default: r = di;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sh7604_ibus_master.sv
// SH7604 internal-bus master: turns single CPU accesses into IBUS cycles.
// Ports: CLK/RST_N/CE_R/CE_F/EN control; CPU_* request side; IBUS_* bus side.
module sh7604_ibus_master
    import SH7604_PKG::*;
#(
    parameter logic [7:0] TO_MAX = 8'd255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        EN,

    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_WE,
    input  logic        CPU_REQ,
    output logic [31:0] CPU_DO,
    output logic        CPU_ACK,
    output logic        CPU_AERR,
    output logic        CPU_BERR,

    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic [31:0] IBUS_DI,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    IBUS_ST_t   st;
    IBUS_SZ_t   cur_sz;
    logic [7:0] to_cnt;

    IBUS_SZ_t   req_sz;
    logic       req_bad;
    logic [31:0] rd_data;

    // CE_F only exists so callers can align to the falling phase.
    logic unused_ce_f;
    assign unused_ce_f = CE_F;

    assign req_sz  = sz_decode(CPU_SZ);
    assign req_bad = misaligned(req_sz, CPU_A[1:0]);
    assign rd_data = lane_extract(cur_sz, IBUS_A[1:0], IBUS_DI);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st       <= IDLE;
            cur_sz   <= SZ_BYTE;
            to_cnt   <= 8'd0;
            IBUS_REQ <= 1'b0;
            IBUS_WE  <= 1'b0;
            IBUS_BA  <= 4'd0;
            IBUS_A   <= 32'd0;
            IBUS_DO  <= 32'd0;
            CPU_DO   <= 32'd0;
            CPU_ACK  <= 1'b0;
            CPU_AERR <= 1'b0;
            CPU_BERR <= 1'b0;
        end else if (CE_R && EN) begin
            case (st)
                IDLE: begin
                    to_cnt <= 8'd0;
                    if (CPU_REQ) begin
                        if (req_bad) begin
                            // Misaligned: report without touching the bus.
                            st       <= DONE;
                            CPU_ACK  <= 1'b1;
                            CPU_AERR <= 1'b1;
                        end else begin
                            st       <= REQ;
                            cur_sz   <= req_sz;
                            IBUS_REQ <= 1'b1;
                            IBUS_A   <= CPU_A;
                            IBUS_WE  <= CPU_WE;
                            IBUS_BA  <= lane_sel(req_sz, CPU_A[1:0]);
                            IBUS_DO  <= lane_wdata(req_sz, CPU_DI);
                        end
                    end
                end

                REQ, WAIT: begin
                    if (IBUS_BUSY && (to_cnt == TO_MAX)) begin
                        // TO_MAX busy periods already tolerated.
                        st       <= DONE;
                        IBUS_REQ <= 1'b0;
                        CPU_ACK  <= 1'b1;
                        CPU_BERR <= 1'b1;
                        CPU_DO   <= 32'd0;
                    end else if (IBUS_BUSY) begin
                        st     <= WAIT;
                        to_cnt <= to_cnt + 8'd1;
                    end else begin
                        st       <= DONE;
                        IBUS_REQ <= 1'b0;
                        CPU_ACK  <= 1'b1;
                        CPU_BERR <= !IBUS_ACT;
                        if (!IBUS_WE) begin
                            CPU_DO <= IBUS_ACT ? rd_data : 32'd0;
                        end
                    end
                end

                DONE: begin
                    st       <= IDLE;
                    CPU_ACK  <= 1'b0;
                    CPU_AERR <= 1'b0;
                    CPU_BERR <= 1'b0;
                end

                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Directed bench for sh7604_ibus_master.
// Drives CPU/IBUS pins, checks against hand-computed values.
module tb_sh7604_ibus_master;

    localparam logic [7:0] TO = 8'd12;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b1;
    logic        ce_ph = 1'b0;
    logic        CE_R;
    logic        CE_F;

    logic [31:0] CPU_A;
    logic [31:0] CPU_DI;
    logic [1:0]  CPU_SZ;
    logic        CPU_WE;
    logic        CPU_REQ;
    logic [31:0] CPU_DO;
    logic        CPU_ACK;
    logic        CPU_AERR;
    logic        CPU_BERR;

    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic [31:0] IBUS_DI;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;
    always @(negedge CLK) ce_ph <= ~ce_ph;
    assign CE_R = ce_ph;
    assign CE_F = ~ce_ph;

    sh7604_ibus_master #(.TO_MAX(TO)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE_R      (CE_R),
        .CE_F      (CE_F),
        .EN        (EN),
        .CPU_A     (CPU_A),
        .CPU_DI    (CPU_DI),
        .CPU_SZ    (CPU_SZ),
        .CPU_WE    (CPU_WE),
        .CPU_REQ   (CPU_REQ),
        .CPU_DO    (CPU_DO),
        .CPU_ACK   (CPU_ACK),
        .CPU_AERR  (CPU_AERR),
        .CPU_BERR  (CPU_BERR),
        .IBUS_A    (IBUS_A),
        .IBUS_DO   (IBUS_DO),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_DI   (IBUS_DI),
        .IBUS_BUSY (IBUS_BUSY),
        .IBUS_ACT  (IBUS_ACT)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next CE_R-qualified rising edge.
    task automatic ce_step();
        @(posedge CLK);
        while (!CE_R) @(posedge CLK);
        #1;
    endtask

    task automatic go(
        input logic [31:0] a,
        input logic [31:0] di,
        input logic [1:0]  sz,
        input logic        we
    );
        CPU_A   = a;
        CPU_DI  = di;
        CPU_SZ  = sz;
        CPU_WE  = we;
        CPU_REQ = 1'b1;
    endtask

    // Zero-wait access with hand-computed bus fields and result.
    task automatic xfer(
        input string       tag,
        input logic [31:0] a,
        input logic [31:0] di,
        input logic [1:0]  sz,
        input logic        we,
        input logic [31:0] rd,
        input logic        act,
        input logic [3:0]  e_ba,
        input logic [31:0] e_bdo,
        input logic [31:0] e_cdo,
        input logic        e_berr
    );
        IBUS_BUSY = 1'b0;
        IBUS_ACT  = act;
        go(a, di, sz, we);
        ce_step();
        CPU_REQ = 1'b0;
        CPU_A   = ~a;
        CPU_DI  = ~di;
        check({tag, "_req"}, IBUS_REQ, 1);
        check({tag, "_ba"},  IBUS_BA,  e_ba);
        check({tag, "_bdo"}, IBUS_DO,  e_bdo);
        check({tag, "_a"},   IBUS_A,   a);
        check({tag, "_we"},  IBUS_WE,  we);
        check({tag, "_ack0"}, CPU_ACK, 0);
        IBUS_DI = rd;
        ce_step();
        check({tag, "_ack"},  CPU_ACK,  1);
        check({tag, "_reqlo"}, IBUS_REQ, 0);
        check({tag, "_cdo"},  CPU_DO,   e_cdo);
        check({tag, "_berr"}, CPU_BERR, e_berr);
        check({tag, "_aerr"}, CPU_AERR, 0);
        ce_step();
        check({tag, "_ackend"}, CPU_ACK, 0);
        IBUS_ACT = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        logic got;

        CPU_A = 0; CPU_DI = 0; CPU_SZ = 0; CPU_WE = 0; CPU_REQ = 0;
        IBUS_DI = 0; IBUS_BUSY = 0; IBUS_ACT = 1;

        repeat (4) @(posedge CLK);
        #1;
        check("rst_req",  IBUS_REQ, 0);
        check("rst_we",   IBUS_WE,  0);
        check("rst_ba",   IBUS_BA,  0);
        check("rst_a",    IBUS_A,   0);
        check("rst_bdo",  IBUS_DO,  0);
        check("rst_cdo",  CPU_DO,   0);
        check("rst_ack",  CPU_ACK,  0);
        check("rst_aerr", CPU_AERR, 0);
        check("rst_berr", CPU_BERR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        ce_step();
        check("idle_req", IBUS_REQ, 0);

        xfer("bw", 32'hFFFFFE91, 32'h0000005A, 2'd0, 1'b1,
             32'h0, 1'b1, 4'b0100, 32'h5A5A5A5A, 32'h0, 1'b0);
        xfer("br", 32'hFFFFFE91, 32'h0, 2'd0, 1'b0,
             32'h00070000, 1'b1, 4'b0100, 32'h0, 32'h00000007, 1'b0);
        xfer("wr", 32'hFFFFFE92, 32'h0, 2'd1, 1'b0,
             32'h1234ABCD, 1'b1, 4'b0011, 32'h0, 32'h0000ABCD, 1'b0);
        xfer("lr", 32'hFFFFFE00, 32'h0, 2'd2, 1'b0,
             32'hDEADBEEF, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
        xfer("ww", 32'hFFFFFE90, 32'hFFFF1234, 2'd1, 1'b1,
             32'h0, 1'b1, 4'b1100, 32'h12341234, 32'hDEADBEEF, 1'b0);
        xfer("b3", 32'hFFFFFE03, 32'h0, 2'd0, 1'b0,
             32'hAABBCCDD, 1'b1, 4'b0001, 32'h0, 32'h000000DD, 1'b0);
        xfer("nact", 32'hFFFFFE00, 32'h0, 2'd0, 1'b0,
             32'hFFFFFFFF, 1'b0, 4'b1000, 32'h0, 32'h0, 1'b1);

        // Wait states: BUSY sampled high for 3 periods.
        IBUS_BUSY = 1'b1;
        go(32'h00000C02, 32'h0, 2'd1, 1'b0);
        ce_step();
        CPU_REQ = 1'b0;
        CPU_A = 32'h55555555; CPU_SZ = 2'd2; CPU_WE = 1'b1;
        check("ws_req0", IBUS_REQ, 1);
        for (int i = 0; i < 3; i++) begin
            ce_step();
            check("ws_req", IBUS_REQ, 1);
            check("ws_ack", CPU_ACK,  0);
            check("ws_a",   IBUS_A,   32'h00000C02);
            check("ws_ba",  IBUS_BA,  4'b0011);
            check("ws_we",  IBUS_WE,  0);
        end
        IBUS_BUSY = 1'b0;
        IBUS_DI = 32'h1111BEEF;
        ce_step();
        check("ws_done", CPU_ACK,  1);
        check("ws_cdo",  CPU_DO,   32'h0000BEEF);
        check("ws_berr", CPU_BERR, 0);
        ce_step();

        // Timeout with BUSY stuck high.
        IBUS_BUSY = 1'b1;
        IBUS_DI = 32'hFFFFFFFF;
        go(32'h00000200, 32'h0, 2'd2, 1'b0);
        ce_step();
        CPU_REQ = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 400 && !got) begin
            ce_step();
            n++;
            if (CPU_ACK) got = 1'b1;
        end
        check("to_steps", n, TO + 1);
        check("to_berr", CPU_BERR, 1);
        check("to_cdo",  CPU_DO,   0);
        check("to_breq", IBUS_REQ, 0);
        ce_step();
        IBUS_BUSY = 1'b0;

        // Misaligned long, CPU_REQ held through DONE.
        go(32'hFFFFFE02, 32'h0, 2'd2, 1'b0);
        ce_step();
        check("al_ack",  CPU_ACK,  1);
        check("al_aerr", CPU_AERR, 1);
        check("al_req",  IBUS_REQ, 0);
        check("al_berr", CPU_BERR, 0);
        ce_step();
        check("al_gap",  CPU_ACK,  0);
        check("al_gape", CPU_AERR, 0);
        CPU_REQ = 1'b0;
        ce_step();
        check("al_idle", CPU_ACK,  0);

        // EN freeze during WAIT.
        IBUS_BUSY = 1'b1;
        go(32'hFFFFFE01, 32'h0, 2'd0, 1'b0);
        ce_step();
        CPU_REQ = 1'b0;
        ce_step();
        EN = 1'b0;
        IBUS_BUSY = 1'b0;
        IBUS_DI = 32'h00C30000;
        repeat (5) begin
            ce_step();
            check("en_req", IBUS_REQ, 1);
            check("en_ack", CPU_ACK,  0);
        end
        EN = 1'b1;
        ce_step();
        check("en_done", CPU_ACK, 1);
        check("en_cdo",  CPU_DO,  32'h000000C3);
        ce_step();

        // Reset mid-WAIT.
        IBUS_BUSY = 1'b1;
        go(32'h00000100, 32'h11223344, 2'd2, 1'b1);
        ce_step();
        CPU_REQ = 1'b0;
        ce_step();
        check("mr_req1", IBUS_REQ, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mr_req",  IBUS_REQ, 0);
        check("mr_we",   IBUS_WE,  0);
        check("mr_ba",   IBUS_BA,  0);
        check("mr_a",    IBUS_A,   0);
        check("mr_bdo",  IBUS_DO,  0);
        check("mr_cdo",  CPU_DO,   0);
        check("mr_ack",  CPU_ACK,  0);
        check("mr_aerr", CPU_AERR, 0);
        check("mr_berr", CPU_BERR, 0);
        IBUS_BUSY = 1'b0;
        IBUS_ACT = 1'b1;
        IBUS_DI = 32'hAB000000;
        go(32'h00000010, 32'h0, 2'd0, 1'b0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        ce_step();
        check("rr_req", IBUS_REQ, 1);
        check("rr_ack", CPU_ACK,  0);
        check("rr_a",   IBUS_A,   32'h00000010);
        CPU_REQ = 1'b0;
        ce_step();
        check("rr_done", CPU_ACK, 1);
        check("rr_cdo",  CPU_DO,  32'h000000AB);
        ce_step();
        check("rr_end",  CPU_ACK, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
